coso_readout_ctrl: RTL and testbench
====================================

Name: coso_readout_ctrl

Overview:
- Controller stage directly downstream of the coherent sampler.
- Performs the req/ack handshake with the sampler and captures each stable counter value.
- Extracts the counter LSB as the raw entropy bit, packs bits into output words and exposes them on a valid/ready interface.
- Also drives a raw-counter tap and a stuck-counter alarm for health monitoring; runs entirely in the system clock domain.

Parameters:
cntWidth, 16, width of the sampler counter input.
wordWidth, 32, number of entropy bits packed per output word (2..64).
zeroLimit, 8, consecutive zero-valued counter reads that raise the alarm (1..255).

Ports:
clk  input  1  system clock; all state on rising edge.
rstN  input  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
req  input  1  sampler request, asynchronous to clk.
cnt  input  cntWidth  sampler counter; stable while req is high.
ack  output  1  acknowledge to sampler; registered.
rawCnt  output  cntWidth  last captured counter value.
rawValid  output  1  one-cycle pulse when rawCnt updates.
word  output  wordWidth  packed entropy word.
wordValid  output  1  word available.
wordReady  input  1  consumer accepts word when wordValid & wordReady.
alarm  output  1  sticky stuck-counter alarm; cleared only by reset.

Behaviour:
- Reset (rstN=0, async): ack=0, rawCnt=0, rawValid=0, word=0, wordValid=0, alarm=0; FSM in IDLE; bit count=0; zero run count=0; sync flops cleared.
- req passes through a 2-flop synchroniser (reqS). Latency from req rising to reqS high is 2 clk edges.
- cnt is not synchronised. It is sampled only in CAPTURE, which is entered after reqS is already high, so cnt has settled.
- FSM states:
  - IDLE: if reqS=1 and packer not full -> CAPTURE. If reqS=1 and packer full (wordValid=1 and not wordReady), stay in IDLE and do not ack; this is backpressure, and the sampler stalls.
  - CAPTURE (1 cycle): rawCnt<=cnt, rawValid=1 for this cycle. Shift cnt[0] into the packer. Update the zero-run count. -> ACK.
  - ACK: ack=1; remain until reqS=0 -> RELEASE.
  - RELEASE (1 cycle): ack=0 -> IDLE. This guarantees ack is low for at least one cycle before the next capture.
- ack is high exactly in ACK state, registered, with no combinational path from req.
- Packer:
  - Bits shift in LSB-first: the first captured bit lands at word[0] and the last at word[wordWidth-1].
  - When bit wordWidth is captured, word is loaded from the shift register and wordValid=1 the next cycle. The bit count wraps to 0.
  - wordValid stays high, and word is stable, until the wordValid&wordReady handshake.
  - A capture that completes a new word is allowed in the same cycle as a handshake on the previous word.
  - Packer full = wordValid=1 and the shift register holds wordWidth-1 bits; in that state the next capture is blocked unless wordReady=1.
- Zero run:
  - The count increments on each capture with cnt==0 and saturates at zeroLimit; it resets to 0 on any capture with cnt!=0.
  - alarm <= 1 when the count reaches zeroLimit.
  - Bits still flow after alarm; the consumer decides.
- rstN asserted mid-handshake: ack drops asynchronously and any partial word is discarded.
- req dropping in IDLE before capture (glitch): no capture, no ack.

Decomposition:
- Shared package coso_pkg: FSM state encoding (IDLE, CAPTURE, ACK, RELEASE, 2 bits) and the synchroniser depth constant (2).
- Sub-module: sync2 (2-flop synchroniser, async active-low clear), reused for every req-type crossing.

Test Plan:
- Basic handshake: req rises with cnt=16'h0005 -> ack high within 4 clk; rawCnt=5 with one rawValid pulse; ack low 2–4 clk after req falls.
- Packing: 32 captures with cnt LSBs alternating 1,0,... starting with 1 -> word=32'h55555555, wordValid high until wordReady pulse.
- Backpressure: full word held with wordReady=0 and 31 more bits captured, then req held high -> ack stays 0 indefinitely; wordReady=1 -> capture proceeds, ack asserts.
- Alarm: 8 consecutive captures with cnt=0 -> alarm=1 after the 8th; a 9th capture with cnt=3 leaves alarm=1 while the run count resets.
- Alarm non-trigger: 7 zeros, one cnt=1, 7 zeros -> alarm stays 0.
- Reset mid-ACK: rstN low while ack=1 -> ack=0 immediately (async), wordValid=0; after release the first capture lands in word[0].

Source files
------------

// File: rtl/coso_pkg.sv
// Shared definitions for the coherent-sampler readout controller.
package coso_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StAck     = 2'd2,
        StRelease = 2'd3
    } state_e;

    localparam int unsigned SyncDepth = 2;

endpackage

// File: rtl/sync2.sv
// Multi-flop synchroniser with asynchronous active-low clear; used for req-type crossings.
module sync2 import coso_pkg::*; #(
    parameter int unsigned Depth = SyncDepth
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [Depth-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[Depth-2:0], i_d};
        end
    end

    assign o_q = r_sync[Depth-1];

endmodule

// File: rtl/coso_readout_ctrl.sv
// Sampler req/ack controller: captures counter values, packs LSBs into words, flags stuck-at-zero.
module coso_readout_ctrl import coso_pkg::*; #(
    parameter int unsigned CntWidth  = 16,
    parameter int unsigned WordWidth = 32,
    parameter int unsigned ZeroLimit = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req,
    input  logic [CntWidth-1:0]  i_cnt,
    output logic                 o_ack,
    output logic [CntWidth-1:0]  o_raw_cnt,
    output logic                 o_raw_valid,
    output logic [WordWidth-1:0] o_word,
    output logic                 o_word_valid,
    input  logic                 i_word_ready,
    output logic                 o_alarm
);

    localparam int unsigned BitCntW = $clog2(WordWidth);

    state_e               r_state, w_state_d;
    logic                 w_req_s;
    logic [BitCntW-1:0]   r_bit_cnt;
    logic [WordWidth-1:0] r_shift, r_word, w_shift_d;
    logic                 r_word_valid, r_ack, r_raw_valid, r_alarm;
    logic [CntWidth-1:0]  r_raw_cnt;
    logic [7:0]           r_zero_cnt, w_zero_d;
    logic                 w_capture, w_last_bit, w_full, w_accept;

    sync2 #(.Depth(SyncDepth)) u_req_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_req),
        .o_q     (w_req_s)
    );

    assign w_capture  = (r_state == StCapture);
    assign w_last_bit = (r_bit_cnt == BitCntW'(WordWidth - 1));
    assign w_full     = r_word_valid && w_last_bit;
    assign w_accept   = r_word_valid && i_word_ready;
    // Shift in at the MSB so the first captured bit ends up at word[0].
    assign w_shift_d  = {i_cnt[0], r_shift[WordWidth-1:1]};
    assign w_zero_d   = (i_cnt != '0)                   ? 8'd0 :
                        (r_zero_cnt < 8'(ZeroLimit))    ? r_zero_cnt + 8'd1 : r_zero_cnt;

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:    if (w_req_s && (!w_full || i_word_ready)) w_state_d = StCapture;
            StCapture: w_state_d = StAck;
            StAck:     if (!w_req_s) w_state_d = StRelease;
            StRelease: w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_ack        <= 1'b0;
            r_raw_valid  <= 1'b0;
            r_raw_cnt    <= '0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_zero_cnt   <= '0;
            r_alarm      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_ack       <= (w_state_d == StAck);
            r_raw_valid <= w_capture;
            if (w_capture) begin
                r_raw_cnt  <= i_cnt;
                r_shift    <= w_shift_d;
                r_zero_cnt <= w_zero_d;
                r_bit_cnt  <= w_last_bit ? '0 : r_bit_cnt + BitCntW'(1);
                if (w_zero_d == 8'(ZeroLimit)) r_alarm <= 1'b1;
            end
            // A completing capture may coincide with the handshake on the previous word.
            if (w_capture && w_last_bit) begin
                r_word       <= w_shift_d;
                r_word_valid <= 1'b1;
            end else if (w_accept) begin
                r_word_valid <= 1'b0;
            end
        end
    end

    assign o_ack        = r_ack;
    assign o_raw_cnt    = r_raw_cnt;
    assign o_raw_valid  = r_raw_valid;
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_alarm      = r_alarm;

endmodule

// File: tb/tb_coso_readout_ctrl.sv
// Directed + randomized bench for coso_readout_ctrl against a bit-list reference model.
module tb_coso_readout_ctrl;

    localparam int unsigned CW = 16;
    localparam int unsigned WW = 32;
    localparam int unsigned ZL = 8;

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic          i_req;
    logic [CW-1:0] i_cnt;
    logic          o_ack;
    logic [CW-1:0] o_raw_cnt;
    logic          o_raw_valid;
    logic [WW-1:0] o_word;
    logic          o_word_valid;
    logic          i_word_ready;
    logic          o_alarm;

    int checks = 0;
    int errors = 0;
    int raw_pulses = 0;

    // Reference model: list of captured bits, zero-run length, sticky alarm, pending word.
    bit            m_bits[$];
    int            m_zero;
    bit            m_alarm;
    bit            m_pending;
    logic [WW-1:0] m_word;

    coso_readout_ctrl #(.CntWidth(CW), .WordWidth(WW), .ZeroLimit(ZL)) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .i_cnt        (i_cnt),
        .o_ack        (o_ack),
        .o_raw_cnt    (o_raw_cnt),
        .o_raw_valid  (o_raw_valid),
        .o_word       (o_word),
        .o_word_valid (o_word_valid),
        .i_word_ready (i_word_ready),
        .o_alarm      (o_alarm)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (o_raw_valid === 1'b1) raw_pulses++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_bits.delete();
        m_zero    = 0;
        m_alarm   = 1'b0;
        m_pending = 1'b0;
        m_word    = '0;
    endfunction

    function automatic void model_capture(input logic [CW-1:0] v);
        m_bits.push_back(v[0]);
        if (v == '0) begin
            if (m_zero < int'(ZL)) m_zero++;
        end else begin
            m_zero = 0;
        end
        if (m_zero == int'(ZL)) m_alarm = 1'b1;
        if (m_bits.size() == int'(WW)) begin
            m_word = '0;
            for (int i = 0; i < int'(WW); i++) m_word = m_word | (WW'(m_bits[i]) << i);
            m_bits.delete();
            m_pending = 1'b1;
        end
    endfunction

    task automatic do_reset();
        i_rst_n      = 1'b0;
        i_req        = 1'b0;
        i_word_ready = 1'b0;
        #2;
        check("rst_ack", 64'(o_ack), 64'd0);
        check("rst_raw_cnt", 64'(o_raw_cnt), 64'd0);
        check("rst_raw_valid", 64'(o_raw_valid), 64'd0);
        check("rst_word", 64'(o_word), 64'd0);
        check("rst_word_valid", 64'(o_word_valid), 64'd0);
        check("rst_alarm", 64'(o_alarm), 64'd0);
        i_rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic capture(input logic [CW-1:0] v);
        int n;
        int p0;
        p0    = raw_pulses;
        i_cnt = v;
        i_req = 1'b1;
        n = 0;
        while (o_ack !== 1'b1 && n < 20) begin tick(); n++; end
        check("ack_rise", 64'(o_ack), 64'd1);
        check("raw_cnt", 64'(o_raw_cnt), 64'(v));
        model_capture(v);
        i_req = 1'b0;
        n = 0;
        while (o_ack !== 1'b0 && n < 20) begin tick(); n++; end
        check("ack_fall", 64'(o_ack), 64'd0);
        check("ack_fall_lat", 64'(n >= 2 && n <= 4), 64'd1);
        check("raw_pulse", 64'(raw_pulses - p0), 64'd1);
        check("alarm", 64'(o_alarm), 64'(m_alarm));
        check("word_valid", 64'(o_word_valid), 64'(m_pending));
        if (m_pending) check("word", 64'(o_word), 64'(m_word));
        tick();
    endtask

    task automatic accept();
        i_word_ready = 1'b1;
        tick();
        i_word_ready = 1'b0;
        m_pending = 1'b0;
        check("word_accept", 64'(o_word_valid), 64'd0);
    endtask

    initial begin
        logic [CW-1:0] v;
        int            p0;
        int            n;
        bit            first_bit;

        i_rst_n = 1'b0; i_req = 1'b0; i_cnt = '0; i_word_ready = 1'b0;
        model_reset();
        tick();
        do_reset();

        // Basic handshake.
        capture(16'h0005);

        // Short req pulse between clock edges must not be captured.
        p0 = raw_pulses;
        i_req = 1'b1; #2; i_req = 1'b0;
        repeat (6) tick();
        check("glitch_ack", 64'(o_ack), 64'd0);
        check("glitch_raw", 64'(raw_pulses - p0), 64'd0);

        // Packing: alternating LSBs starting with 1.
        do_reset();
        for (int i = 0; i < int'(WW); i++) begin
            v = CW'($urandom) & 16'hfffe;
            v[0] = ((i % 2) == 0);
            capture(v);
        end
        check("pack_55", 64'(o_word), 64'h5555_5555);
        repeat (5) tick();
        check("pack_hold_valid", 64'(o_word_valid), 64'd1);
        check("pack_hold_word", 64'(o_word), 64'h5555_5555);
        accept();

        // Backpressure: hold a full word and fill the next one to WW-1 bits.
        for (int i = 0; i < int'(WW); i++) capture(CW'($urandom));
        for (int i = 0; i < int'(WW) - 1; i++) capture(CW'($urandom));
        v = CW'($urandom);
        p0 = raw_pulses;
        i_cnt = v;
        i_req = 1'b1;
        repeat (12) tick();
        check("bp_no_ack", 64'(o_ack), 64'd0);
        check("bp_no_raw", 64'(raw_pulses - p0), 64'd0);
        check("bp_word_held", 64'(o_word), 64'(m_word));
        i_word_ready = 1'b1;
        tick();
        i_word_ready = 1'b0;
        m_pending = 1'b0;
        capture(v);
        accept();

        // Random captures with random consumer acceptance.
        for (int i = 0; i < 70; i++) begin
            if (m_pending && (m_bits.size() == int'(WW) - 1 || $urandom_range(0, 3) == 0))
                accept();
            v = CW'($urandom);
            if ($urandom_range(0, 5) == 0) v = '0;
            capture(v);
        end

        // Alarm: ZL zeros trigger, a non-zero afterwards leaves it set.
        do_reset();
        for (int i = 0; i < int'(ZL); i++) capture('0);
        check("alarm_set", 64'(o_alarm), 64'd1);
        capture(16'h0003);
        check("alarm_sticky", 64'(o_alarm), 64'd1);

        // Alarm non-trigger: run broken by a non-zero value.
        do_reset();
        for (int i = 0; i < int'(ZL) - 1; i++) capture('0);
        capture(16'h0001);
        for (int i = 0; i < int'(ZL) - 1; i++) capture('0);
        check("alarm_quiet", 64'(o_alarm), 64'd0);

        // Reset mid-ACK with a pending word and a partial word.
        do_reset();
        for (int i = 0; i < int'(WW) + 5; i++) capture(CW'($urandom) | 16'h0100);
        i_cnt = CW'($urandom);
        i_req = 1'b1;
        n = 0;
        while (o_ack !== 1'b1 && n < 20) begin tick(); n++; end
        check("midack_ack", 64'(o_ack), 64'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("midack_ack_drop", 64'(o_ack), 64'd0);
        check("midack_wv_drop", 64'(o_word_valid), 64'd0);
        i_req = 1'b0;
        #2;
        i_rst_n = 1'b1;
        model_reset();
        tick();
        first_bit = 1'b0;
        for (int i = 0; i < int'(WW); i++) begin
            v = CW'($urandom);
            if (i == 0) first_bit = v[0];
            capture(v);
        end
        check("midack_bit0", 64'(o_word[0]), 64'(first_bit));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
